bubble_page_loader: RTL
=======================

BUBBLE_PAGE_LOADER -- requirements
Module: bubble_page_loader

Interface
REQ-001 SHALL have parameter BOOTBYTES, default 480, meaning bootloader length in bytes.
REQ-002 SHALL have parameter PAGEBYTES, default 146, meaning user page length in bytes (1168 bits).
REQ-003 SHALL have port MCLK  input  1  48MHz clock; all logic on posedge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port START  input  1  one-cycle load request.
REQ-006 SHALL have port ACCTYPE  input  3  sampled with START; 3'b110 BOOT, 3'b111 USER.
REQ-007 SHALL have port BYTEDATA  input  8  source byte.
REQ-008 SHALL have port BYTEVALID  input  1  BYTEDATA valid.
REQ-009 SHALL have port BYTEREADY  output  1  byte accepted this cycle when high with BYTEVALID.
REQ-010 SHALL have port nOUTBUFWCLKEN  output  1  active-low one-bit write strobe to bubble outbuffer.
REQ-011 SHALL have port OUTBUFWADDR  output  15  {13-bit buffer position, channel}; bit0 0 = DOUT1, 1 = DOUT0.
REQ-012 SHALL have port OUTBUFWDATA  output  1  bit to write.
REQ-013 SHALL have port BUSY  output  1  load in progress.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse at load completion.

Function
REQ-015 SHALL implement states IDLE, PREFILL, FETCH, SHIFT, FINISH.
REQ-016 In IDLE, START with ACCTYPE=BOOT SHALL load OUTBUFWADDR base 4106 (position 2053, ch0) and byte count BOOTBYTES, then go to FETCH.
REQ-017 In IDLE, START with ACCTYPE=USER SHALL load OUTBUFWADDR base 14336 (position 7168, ch0) and byte count PAGEBYTES, then go to PREFILL.
REQ-018 START with any other ACCTYPE, or START while BUSY, SHALL be ignored with no state change.
REQ-019 PREFILL SHALL issue 6 consecutive zero-bit writes (addresses 14336..14341), then go to FETCH.
REQ-020 FETCH SHALL assert BYTEREADY; on BYTEVALID&BYTEREADY it SHALL capture BYTEDATA into a shift register and go to SHIFT; otherwise it SHALL wait indefinitely with no write strobe.
REQ-021 SHALL deassert BYTEREADY in all states other than FETCH.
REQ-022 SHIFT SHALL issue exactly 8 writes on 8 consecutive cycles, LSB first.
REQ-023 After 8 writes, SHIFT SHALL decrement the byte count, returning to FETCH if it is nonzero, else going to FINISH.
REQ-024 Each write SHALL be one cycle with nOUTBUFWCLKEN=0, with OUTBUFWADDR and OUTBUFWDATA stable for that whole cycle; the buffer samples at the following negedge.
REQ-025 OUTBUFWADDR SHALL increment by 1 after every write, so channels alternate DOUT1, DOUT0, DOUT1, ...
REQ-026 Write addresses SHALL span 4106..7945 for BOOT (3840 writes) and 14336..15509 for USER (6+1168 writes).
REQ-027 The address register SHALL NOT wrap; the 15-bit width suffices and no address beyond the last write SHALL be driven with a strobe.
REQ-028 nOUTBUFWCLKEN SHALL be 1 in IDLE, FETCH and FINISH.
REQ-029 FINISH SHALL pulse DONE for one cycle and return to IDLE.
REQ-030 BUSY SHALL be 1 in PREFILL, FETCH, SHIFT and FINISH, and 0 in IDLE.
REQ-031 START in the cycle where FINISH returns to IDLE SHALL be ignored; the earliest accepted START is the first cycle in IDLE.
REQ-032 First write strobe latency SHALL be 1 cycle after START for USER (PREFILL), and 1 cycle after byte handshake for BOOT.

Reset
REQ-033 RESET SHALL force IDLE, nOUTBUFWCLKEN=1, BYTEREADY=0, BUSY=0, DONE=0, OUTBUFWADDR=0, OUTBUFWDATA=0, and clear counters and the shift register.
REQ-034 RESET mid-load SHALL abort within the same edge: no further strobes and no DONE; the partially written buffer is left as is.
REQ-035 RESET SHALL have priority over START.

Verification
REQ-036 BOOT load, BYTEVALID held high, byte i = i[7:0] -> 3840 strobes at 4106..7945, no gaps except 1 FETCH cycle per byte, DONE once, byte 1 bit0=1 written at 4114.
REQ-037 USER load, bytes 8'hA5 -> 6 zero writes at 14336..14341, then data pattern 1,0,1,0,0,1,0,1 repeating, last strobe at 15509, DONE once.
REQ-038 BYTEVALID stalls of 0..20 random cycles during BOOT -> no strobe while in FETCH; final address and data content identical to the unstalled run.
REQ-039 START with ACCTYPE=3'b000, and a second START while BUSY -> ignored, BUSY unaffected, no extra strobe.
REQ-040 RESET asserted after 100 USER writes -> next cycle nOUTBUFWCLKEN=1, BUSY=0, no DONE; a new BOOT START then completes normally.
REQ-041 Scoreboard bench with a behavioural outbuffer model (negedge write, channel per bit0) -> buffer contents match the expected image after BOOT then USER loads.

Source files
------------

// File: rtl/bubble_page_loader_if.sv
// Byte-source handshake, bubble outbuffer write port and load status for the
// bubble page loader.
interface bubble_page_loader_if;
    logic        START;
    logic [2:0]  ACCTYPE;
    logic [7:0]  BYTEDATA;
    logic        BYTEVALID;
    logic        BYTEREADY;
    logic        nOUTBUFWCLKEN;
    logic [14:0] OUTBUFWADDR;
    logic        OUTBUFWDATA;
    logic        BUSY;
    logic        DONE;

    // Requester / byte source / buffer side
    modport master (
        output START, ACCTYPE, BYTEDATA, BYTEVALID,
        input  BYTEREADY, nOUTBUFWCLKEN, OUTBUFWADDR, OUTBUFWDATA, BUSY, DONE
    );

    // Loader side
    modport slave (
        input  START, ACCTYPE, BYTEDATA, BYTEVALID,
        output BYTEREADY, nOUTBUFWCLKEN, OUTBUFWADDR, OUTBUFWDATA, BUSY, DONE
    );
endinterface

// File: rtl/bubble_page_loader.sv
// Bubble page loader: pulls bytes from a ready/valid source and serialises
// them LSB first into the bubble outbuffer, one bit per cycle, with an
// incrementing {position, channel} address. USER pages get six leading zero
// bits. All outputs are registered.
module bubble_page_loader #(
    parameter int BOOTBYTES = 480,
    parameter int PAGEBYTES = 146
) (
    input  logic                  MCLK,
    input  logic                  RESET,
    bubble_page_loader_if.slave   bus
);
    localparam int MAXBYTES = (BOOTBYTES > PAGEBYTES) ? BOOTBYTES : PAGEBYTES;
    localparam int CNT_W    = $clog2(MAXBYTES + 1);

    localparam logic [2:0]  ACC_BOOT  = 3'b110;
    localparam logic [2:0]  ACC_USER  = 3'b111;
    localparam logic [14:0] BOOT_BASE = 15'd4106;   // position 2053, ch0
    localparam logic [14:0] USER_BASE = 15'd14336;  // position 7168, ch0

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        FETCH,
        SHIFT,
        FINISH
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [2:0]         bit_cnt;    // bit index in SHIFT, zero-write index in PREFILL
    logic [7:0]         shreg;
    logic               ready_r;
    logic               wen_n_r;
    logic [14:0]        addr_r;
    logic               data_r;
    logic               busy_r;
    logic               done_r;

    assign bus.BYTEREADY     = ready_r;
    assign bus.nOUTBUFWCLKEN = wen_n_r;
    assign bus.OUTBUFWADDR   = addr_r;
    assign bus.OUTBUFWDATA   = data_r;
    assign bus.BUSY          = busy_r;
    assign bus.DONE          = done_r;

    // Load sequencer; outputs are registered so each write cycle's strobe,
    // address and data change together on the clock edge.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state    <= IDLE;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ready_r  <= 1'b0;
            wen_n_r  <= 1'b1;
            addr_r   <= '0;
            data_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // Every completed write advances the address; this never runs
            // past the last write because the strobe stops there.
            if (!wen_n_r) begin
                addr_r <= addr_r + 15'd1;
            end

            case (state)
                IDLE: begin
                    if (bus.START && bus.ACCTYPE == ACC_BOOT) begin
                        state    <= FETCH;
                        addr_r   <= BOOT_BASE;
                        byte_cnt <= CNT_W'(BOOTBYTES);
                        busy_r   <= 1'b1;
                        ready_r  <= 1'b1;
                    end else if (bus.START && bus.ACCTYPE == ACC_USER) begin
                        state    <= PREFILL;
                        addr_r   <= USER_BASE;
                        byte_cnt <= CNT_W'(PAGEBYTES);
                        busy_r   <= 1'b1;
                        bit_cnt  <= '0;
                        wen_n_r  <= 1'b0;
                        data_r   <= 1'b0;
                    end
                end

                PREFILL: begin
                    if (bit_cnt == 3'd5) begin
                        state   <= FETCH;
                        bit_cnt <= '0;
                        wen_n_r <= 1'b1;
                        ready_r <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end

                FETCH: begin
                    if (bus.BYTEVALID) begin
                        state   <= SHIFT;
                        shreg   <= bus.BYTEDATA;
                        data_r  <= bus.BYTEDATA[0];
                        bit_cnt <= '0;
                        wen_n_r <= 1'b0;
                        ready_r <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (bit_cnt == 3'd7) begin
                        byte_cnt <= byte_cnt - CNT_W'(1);
                        bit_cnt  <= '0;
                        wen_n_r  <= 1'b1;
                        if (byte_cnt == CNT_W'(1)) begin
                            state  <= FINISH;
                            done_r <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            ready_r <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shreg   <= shreg >> 1;
                        data_r  <= shreg[1];
                    end
                end

                FINISH: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b0;
                    wen_n_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
